// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst memory: burst and response codes,
// FSM state encodings and the transfer-size-to-byte-count helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  // Bytes per beat for an AXI size code (2**size).
  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for one AXI channel.
// Ports:
//   i_addr  - address of the current beat (memory-local, AW bits)
//   i_size  - AXI size code of the burst
//   i_len   - AXI len (beats-1) of the burst
//   i_burst - AXI burst type
//   o_next  - address of the following beat, modulo 2**AW
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  logic [7:0]    i_len,
  input  logic [1:0]    i_burst,
  output logic [AW-1:0] o_next
);

  logic [31:0] addr_ext_s;
  logic [31:0] bytes_s;
  logic [31:0] aligned_s;
  logic [31:0] incr_s;
  logic [31:0] wrap_mask_s;
  logic [31:0] wrap_s;
  logic        wrap_ok_s;

  // Compute the INCR and WRAP candidates and pick one by burst type.
  always_comb begin
    addr_ext_s  = 32'(i_addr);
    bytes_s     = 32'(size_bytes(i_size));
    // The first beat may be unaligned; later beats step from the aligned base.
    aligned_s   = addr_ext_s & ~(bytes_s - 32'd1);
    incr_s      = aligned_s + bytes_s;
    // Wrap window is (len+1)*bytes, itself a power of two for legal lengths.
    wrap_mask_s = ((32'(i_len) + 32'd1) << i_size) - 32'd1;
    wrap_s      = (addr_ext_s & ~wrap_mask_s) | (incr_s & wrap_mask_s);
    wrap_ok_s   = (i_len == 8'd1) || (i_len == 8'd3) ||
                  (i_len == 8'd7) || (i_len == 8'd15);
    case (i_burst)
      BURST_FIXED: o_next = i_addr;
      BURST_WRAP: begin
        if (wrap_ok_s) begin
          o_next = wrap_s[AW-1:0];
        end else begin
          o_next = incr_s[AW-1:0];
        end
      end
      default: o_next = incr_s[AW-1:0];
    endcase
  end

endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 slave on-chip memory (boot ROM / scratch RAM).
// Independent read and write channels, one outstanding transaction each,
// one beat per cycle. FIXED/INCR/WRAP bursts and narrow transfers.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   i_aw* / o_awready          - write address channel
//   i_w*  / o_wready           - write data channel
//   o_b*  / i_bready           - write response channel
//   i_ar* / o_arready          - read address channel
//   o_r*  / i_rready           - read data channel
// Only the low log2(MEM_SIZE) address bits are decoded; the address space
// wraps at the top of memory. READ_ONLY discards writes and answers SLVERR.
module axi_burst_mem
  import axi_pkg::*;
#(
  parameter int    ID_WIDTH   = 6,
  parameter int    DATA_WIDTH = 64,
  parameter int    MEM_SIZE   = 4096,
  parameter string INIT_FILE  = "",
  parameter bit    READ_ONLY  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [31:0]             i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [31:0]             i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(MEM_SIZE);
  localparam int OFF   = $clog2(BYTES);
  localparam int WORDS = MEM_SIZE / BYTES;
  localparam int WA    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [AW-1:0]         aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [7:0]            w_beat_q, w_beat_d;
  logic                  w_err_q, w_err_d;
  logic [AW-1:0]         aw_next_s;
  logic                  wr_en_s;
  logic [WA-1:0]         wr_idx_s;

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [AW-1:0]         ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [AW-1:0]         ar_next_s;
  logic                  rd_en_s;
  logic [AW-1:0]         rd_addr_s;
  logic [WA-1:0]         rd_idx_s;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Upper address bits are intentionally ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^{i_awaddr[31:AW], i_araddr[31:AW]};

  // Power-up contents: zero-filled array.
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = '0;
    end
  end

  axi_burst_addr #(.AW(AW)) u_aw_addr (
    .i_addr  (aw_addr_q),
    .i_size  (aw_size_q),
    .i_len   (aw_len_q),
    .i_burst (aw_burst_q),
    .o_next  (aw_next_s)
  );

  axi_burst_addr #(.AW(AW)) u_ar_addr (
    .i_addr  (ar_addr_q),
    .i_size  (ar_size_q),
    .i_len   (ar_len_q),
    .i_burst (ar_burst_q),
    .o_next  (ar_next_s)
  );

  // Write FSM next-state, handshakes and memory write enable.
  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_err_d    = w_err_q;
    wr_en_s    = 1'b0;
    wr_idx_s   = WA'(aw_addr_q >> OFF);
    case (w_state_q)
      W_IDLE: begin
        // awready comes up one cycle after reset release.
        awready_d = 1'b1;
        if (i_awvalid && awready_q) begin
          aw_id_d    = i_awid;
          aw_addr_d  = i_awaddr[AW-1:0];
          aw_len_d   = i_awlen;
          aw_size_d  = i_awsize;
          aw_burst_d = i_awburst;
          w_beat_d   = 8'd0;
          w_err_d    = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (i_wvalid && wready_q) begin
          wr_en_s   = !READ_ONLY;
          aw_addr_d = aw_next_s;
          w_beat_d  = w_beat_q + 8'd1;
          // The beat counter, not wlast, decides where the burst ends.
          if (w_beat_q == aw_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (READ_ONLY || w_err_q || !i_wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_err_d = w_err_q | i_wlast;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (i_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'b00;
      w_beat_q   <= 8'd0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_err_q    <= w_err_d;
    end
  end

  // Byte-enable write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wstrb[b]) begin
          mem[wr_idx_s][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM next-state and RAM read request.
  always_comb begin
    r_state_d  = r_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    rd_en_s    = 1'b0;
    rd_addr_s  = ar_addr_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (i_arvalid && arready_q) begin
          ar_id_d    = i_arid;
          ar_addr_d  = i_araddr[AW-1:0];
          ar_len_d   = i_arlen;
          ar_size_d  = i_arsize;
          ar_burst_d = i_arburst;
          r_beat_d   = 8'd0;
          arready_d  = 1'b0;
          r_state_d  = R_FETCH;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_FETCH: begin
        rd_en_s   = 1'b1;
        rd_addr_s = ar_addr_q;
        rvalid_d  = 1'b1;
        rlast_d   = (ar_len_q == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (i_rready && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            // Fetch the next beat in the handshake cycle so there is no bubble.
            rd_en_s   = 1'b1;
            rd_addr_s = ar_next_s;
            ar_addr_d = ar_next_s;
            r_beat_d  = r_beat_q + 8'd1;
            rlast_d   = ((r_beat_q + 8'd1) == ar_len_q);
          end
        end else begin
          // Stalled: no fetch, so rdata/rlast hold.
          r_state_d = R_DATA;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  assign rd_idx_s = WA'(rd_addr_s >> OFF);

  // Read channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'b00;
      r_beat_q   <= 8'd0;
    end else begin
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
    end
  end

  // Synchronous read port; a same-cycle write to the word is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en_s) begin
      rdata_q <= mem[rd_idx_s];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign o_awready = awready_q;
  assign o_wready  = wready_q;
  assign o_bvalid  = bvalid_q;
  assign o_bresp   = bresp_q;
  assign o_bid     = aw_id_q;
  assign o_arready = arready_q;
  assign o_rvalid  = rvalid_q;
  assign o_rlast   = rlast_q;
  assign o_rid     = ar_id_q;
  assign o_rdata   = rdata_q;
  assign o_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: a read-write and a read-only instance
// share every input, so both see identical traffic.
module tb_axi_burst_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  awid = 6'd0, arid = 6'd0;
  logic [31:0] awaddr = 32'd0, araddr = 32'd0;
  logic [7:0]  awlen = 8'd0, arlen = 8'd0;
  logic [2:0]  awsize = 3'd0, arsize = 3'd0;
  logic [1:0]  awburst = 2'd0, arburst = 2'd0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic [63:0] wdata = 64'd0;
  logic [7:0]  wstrb = 8'd0;
  logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;

  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;
  logic        ro_awready, ro_wready, ro_bvalid, ro_arready, ro_rvalid, ro_rlast;
  logic [5:0]  ro_bid, ro_rid;
  logic [1:0]  ro_bresp, ro_rresp;
  logic [63:0] ro_rdata;

  axi_burst_mem #(.ID_WIDTH(6), .DATA_WIDTH(64), .MEM_SIZE(4096), .INIT_FILE(""), .READ_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
  );

  axi_burst_mem #(.ID_WIDTH(6), .DATA_WIDTH(64), .MEM_SIZE(4096), .INIT_FILE(""), .READ_ONLY(1'b1)) dut_ro (
    .clk(clk), .rst_n(rst_n),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(ro_awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(ro_wready),
    .o_bid(ro_bid), .o_bresp(ro_bresp), .o_bvalid(ro_bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(ro_arready),
    .o_rid(ro_rid), .o_rdata(ro_rdata), .o_rresp(ro_rresp), .o_rlast(ro_rlast), .o_rvalid(ro_rvalid),
    .i_rready(rready)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  int          wr_lat, b_lat, w_beats;
  logic [1:0]  b_resp, ro_b_resp;
  logic [5:0]  b_id;

  logic [63:0] rd_data [16];
  logic [63:0] ro_rd_data [16];
  logic        rd_last [16];
  logic [5:0]  rd_id;
  logic [1:0]  rd_resp;
  int          rd_n, rd_lat, rd_cyc, stall_bad;

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [5:0] id, input int early);
    int cnt;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!awready) begin
      n_cmp++; n_fail++;
      $display("FAIL aw_timeout awready=%b required 1", awready);
      awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_beats = 0;
    wr_lat = -1;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wr_data[b]; wstrb = wr_strb[b];
      wlast = (early >= 0) ? (b == early) : (b == int'(len));
      wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
      if (b == 0) wr_lat = cnt;
      if (!wready) begin
        n_cmp++; n_fail++;
        $display("FAIL w_timeout beat=%0d wready=%b required 1", b, wready);
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
      @(posedge clk); #1;
      w_beats++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
    b_lat = cnt; b_resp = bresp; ro_b_resp = ro_bresp; b_id = bid;
    if (!bvalid) begin
      n_cmp++; n_fail++;
      $display("FAIL b_timeout bvalid=%b required 1", bvalid);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [5:0] id, input bit rnd);
    int cnt;
    logic hold_v;
    logic [63:0] hold_d;
    logic hold_l;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    rd_n = 0; rd_cyc = 0; stall_bad = 0; rd_resp = 2'b00; rd_lat = 0;
    while (!arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!arready) begin
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout arready=%b required 1", arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rd_lat = 1;
    while (!rvalid && rd_lat < 50) begin @(posedge clk); #1; rd_lat++; end
    if (!rvalid) begin
      n_cmp++; n_fail++;
      $display("FAIL r_timeout rvalid=%b required 1", rvalid);
      return;
    end
    hold_v = 1'b0; hold_d = 64'd0; hold_l = 1'b0;
    while (rd_n <= int'(len) && rd_cyc < 400) begin
      rready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (hold_v && (rdata !== hold_d || rlast !== hold_l)) stall_bad++;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; ro_rd_data[rd_n] = ro_rdata; rd_last[rd_n] = rlast;
        rd_id = rid; rd_resp = rd_resp | rresp;
        rd_n++;
        hold_v = 1'b0;
      end else if (rvalid) begin
        hold_v = 1'b1; hold_d = rdata; hold_l = rlast;
      end else begin
        hold_v = 1'b0;
      end
      @(posedge clk); #1;
      rd_cyc++;
    end
    rready = 1'b0;
    if (rd_n <= int'(len)) begin
      n_cmp++; n_fail++;
      $display("FAIL r_beats_timeout got=%0d required %0d", rd_n, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, bid, rid, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs awready=%b arready=%b wready=%b bvalid=%b rvalid=%b rdata=%h required all 0",
               awready, arready, wready, bvalid, rvalid, rdata);
    end
    rst_n = 1'b1;
    n_cmp++;
    if ({awready, arready} !== 2'b00) begin
      n_fail++; $display("FAIL ready_before_edge got=%b required 00", {awready, arready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset got=%b required 11", {awready, arready});
    end
  endtask

  task automatic test_incr();
    logic [63:0] exp [4];
    logic [3:0] lv;
    exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33; exp[3] = 64'h44;
    for (int k = 0; k < 4; k++) begin wr_data[k] = exp[k]; wr_strb[k] = 8'hFF; end
    do_write(32'h10, 8'd3, 3'd3, 2'b01, 6'h2A, -1);
    n_cmp++; if (w_beats !== 4) begin n_fail++; $display("FAIL incr_w_beats got=%0d required 4", w_beats); end
    n_cmp++; if (wr_lat !== 0) begin n_fail++; $display("FAIL aw_to_wready got=%0d required 0 extra cycles", wr_lat); end
    n_cmp++; if (b_lat !== 0) begin n_fail++; $display("FAIL wlast_to_bvalid got=%0d required 0 extra cycles", b_lat); end
    n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp got=%b required 00", b_resp); end
    n_cmp++; if (b_id !== 6'h2A) begin n_fail++; $display("FAIL incr_bid got=%h required 2a", b_id); end
    do_read(32'h10, 8'd3, 3'd3, 2'b01, 6'h15, 1'b0);
    n_cmp++; if (rd_lat !== 2) begin n_fail++; $display("FAIL incr_ar_to_rvalid got=%0d required 2", rd_lat); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rd_data[k] !== exp[k]) begin n_fail++; $display("FAIL incr_rdata beat=%0d got=%h required %h", k, rd_data[k], exp[k]); end
    end
    lv = 4'b0000;
    for (int k = 0; k < 4; k++) lv[k] = rd_last[k];
    n_cmp++; if (lv !== 4'b1000) begin n_fail++; $display("FAIL incr_rlast got=%b required 1000", lv); end
    n_cmp++; if (rd_id !== 6'h15) begin n_fail++; $display("FAIL incr_rid got=%h required 15", rd_id); end
    n_cmp++; if (rd_resp !== 2'b00) begin n_fail++; $display("FAIL incr_rresp got=%b required 00", rd_resp); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    wr_data[0] = 64'h55; wr_data[1] = 64'h66; wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    do_write(32'h30, 8'd1, 3'd3, 2'b01, 6'h01, -1);
    exp[0] = 64'h66; exp[1] = 64'h33; exp[2] = 64'h44; exp[3] = 64'h55;
    do_read(32'h38, 8'd3, 3'd3, 2'b10, 6'h03, 1'b0);
    n_cmp++; if (rd_lat !== 2) begin n_fail++; $display("FAIL wrap_ar_to_rvalid got=%0d required 2", rd_lat); end
    n_cmp++; if (rd_cyc !== 4) begin n_fail++; $display("FAIL wrap_beat_cycles got=%0d required 4", rd_cyc); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rd_data[k] !== exp[k]) begin n_fail++; $display("FAIL wrap_rdata beat=%0d got=%h required %h", k, rd_data[k], exp[k]); end
    end
    n_cmp++; if ({rvalid, arready} !== 2'b01) begin n_fail++; $display("FAIL wrap_end rvalid,arready=%b required 01", {rvalid, arready}); end
    // len=2 is not a legal wrap length, so it walks forward: 0x28,0x30,0x38.
    exp[0] = 64'h44; exp[1] = 64'h55; exp[2] = 64'h66;
    do_read(32'h28, 8'd2, 3'd3, 2'b10, 6'h04, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rd_data[k] !== exp[k]) begin n_fail++; $display("FAIL wrap_len2_rdata beat=%0d got=%h required %h", k, rd_data[k], exp[k]); end
    end
  endtask

  task automatic test_addr_wrap();
    wr_data[0] = 64'hAB; wr_data[1] = 64'hCD; wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    do_write(32'hFF8, 8'd1, 3'd3, 2'b01, 6'h05, -1);
    do_read(32'h0, 8'd0, 3'd3, 2'b01, 6'h05, 1'b0);
    n_cmp++; if (rd_data[0] !== 64'hCD) begin n_fail++; $display("FAIL top_wrap_word0 got=%h required cd", rd_data[0]); end
    do_read(32'hFF8, 8'd0, 3'd3, 2'b00, 6'h05, 1'b0);
    n_cmp++; if (rd_data[0] !== 64'hAB) begin n_fail++; $display("FAIL top_word got=%h required ab", rd_data[0]); end
  endtask

  task automatic test_narrow();
    logic [7:0] byte_v;
    wr_data[0] = 64'hFFEEDDCCBBAA9988; wr_data[1] = 64'h7766554433221100;
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    do_write(32'h0, 8'd1, 3'd3, 2'b01, 6'h06, -1);
    for (int k = 0; k < 8; k++) begin
      byte_v = 8'hA0 + 8'(k);
      wr_data[k] = {8{byte_v}};
      wr_strb[k] = 8'd1 << ((3 + k) % 8);
    end
    do_write(32'h3, 8'd7, 3'd0, 2'b01, 6'h06, -1);
    n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL narrow_bresp got=%b required 00", b_resp); end
    do_read(32'h0, 8'd1, 3'd3, 2'b01, 6'h06, 1'b0);
    n_cmp++; if (rd_data[0] !== 64'hA4A3A2A1A0AA9988) begin n_fail++; $display("FAIL narrow_word0 got=%h required a4a3a2a1a0aa9988", rd_data[0]); end
    n_cmp++; if (rd_data[1] !== 64'h7766554433A7A6A5) begin n_fail++; $display("FAIL narrow_word1 got=%h required 7766554433a7a6a5", rd_data[1]); end
  endtask

  task automatic test_read_only();
    wr_data[0] = 64'hDEADBEEF00000001; wr_data[1] = 64'hCAFEF00D00000002;
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
    do_write(32'h40, 8'd1, 3'd3, 2'b01, 6'h07, -1);
    n_cmp++; if (w_beats !== 2) begin n_fail++; $display("FAIL ro_w_beats got=%0d required 2", w_beats); end
    n_cmp++; if (ro_b_resp !== 2'b10) begin n_fail++; $display("FAIL ro_bresp got=%b required 10", ro_b_resp); end
    n_cmp++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL rw_bresp got=%b required 00", b_resp); end
    do_read(32'h40, 8'd1, 3'd3, 2'b01, 6'h07, 1'b0);
    n_cmp++; if (ro_rd_data[0] !== 64'd0) begin n_fail++; $display("FAIL ro_rdata0 got=%h required 0", ro_rd_data[0]); end
    n_cmp++; if (ro_rd_data[1] !== 64'd0) begin n_fail++; $display("FAIL ro_rdata1 got=%h required 0", ro_rd_data[1]); end
    n_cmp++; if (rd_data[1] !== 64'hCAFEF00D00000002) begin n_fail++; $display("FAIL rw_rdata1 got=%h required cafef00d00000002", rd_data[1]); end
  endtask

  task automatic test_stall();
    logic [15:0] lv;
    for (int k = 0; k < 16; k++) begin wr_data[k] = 64'h1000 + 64'(k); wr_strb[k] = 8'hFF; end
    do_write(32'h100, 8'd15, 3'd3, 2'b01, 6'h08, -1);
    do_read(32'h100, 8'd15, 3'd3, 2'b01, 6'h09, 1'b1);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (rd_data[k] !== 64'h1000 + 64'(k)) begin n_fail++; $display("FAIL stall_rdata beat=%0d got=%h required %h", k, rd_data[k], 64'h1000 + 64'(k)); end
    end
    lv = 16'd0;
    for (int k = 0; k < 16; k++) lv[k] = rd_last[k];
    n_cmp++; if (lv !== 16'h8000) begin n_fail++; $display("FAIL stall_rlast got=%h required 8000", lv); end
    n_cmp++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold changes=%0d required 0", stall_bad); end
  endtask

  task automatic test_early_wlast();
    for (int k = 0; k < 4; k++) begin wr_data[k] = 64'h77; wr_strb[k] = 8'hFF; end
    do_write(32'h200, 8'd3, 3'd3, 2'b01, 6'h0A, 1);
    n_cmp++; if (w_beats !== 4) begin n_fail++; $display("FAIL early_w_beats got=%0d required 4", w_beats); end
    n_cmp++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL early_bresp got=%b required 10", b_resp); end
  endtask

  task automatic test_reset_mid_read();
    int cnt;
    arid = 6'h0B; araddr = 32'h100; arlen = 8'd15; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL midburst_rvalid got=%b required 1", rvalid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({rvalid, arready, rlast} !== 3'b000) begin n_fail++; $display("FAIL in_reset rvalid,arready,rlast=%b required 000", {rvalid, arready, rlast}); end
    rst_n = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({arready, awready, rvalid} !== 3'b110) begin n_fail++; $display("FAIL after_reset arready,awready,rvalid=%b required 110", {arready, awready, rvalid}); end
    do_read(32'h10, 8'd0, 3'd3, 2'b01, 6'h0C, 1'b0);
    n_cmp++; if (rd_data[0] !== 64'h11) begin n_fail++; $display("FAIL post_reset_rdata got=%h required 11", rd_data[0]); end
    n_cmp++; if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_rlast got=%b required 1", rd_last[0]); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_addr_wrap();
    test_narrow();
    test_read_only();
    test_stall();
    test_early_wlast();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
